// File: rtl/jam_n_if.sv
// Request/status bundle for the jam_n puzzle engine. The host drives move_en/move/undo
// and the engine reports the board, the empty slot, per-request accept/reject and status.
interface jam_n_if #(
  parameter int N  = 3,
  parameter int CW = 8
);
  localparam int S  = 2*N + 1;
  localparam int MW = $clog2(S);

  logic          move_en;
  logic [MW-1:0] move;
  logic          undo;
  logic [2*S-1:0] slots;
  logic [MW-1:0] empty_pos;
  logic          accept;
  logic          reject;
  logic [CW-1:0] move_cnt;
  logic          done;
  logic          stuck;

  modport master (
    output move_en, move, undo,
    input  slots, empty_pos, accept, reject, move_cnt, done, stuck
  );

  modport slave (
    input  move_en, move, undo,
    output slots, empty_pos, accept, reject, move_cnt, done, stuck
  );
endinterface

// File: rtl/jam_n.sv
// Traffic-jam puzzle engine: N right-facing and N left-facing players in 2N+1 slots.
// Define JAM_UNDO_EN to build the one-level undo history; otherwise undo is ignored.

// Legality of moving the player in one slot, from the slot and its two neighbours
// on each side. Off-board neighbours are fed code 3, which matches no cell rule.
module jam_n_cell #(
  parameter bit STRICT = 1'b0
) (
  input  logic [1:0] c,
  input  logic [1:0] l1,
  input  logic [1:0] l2,
  input  logic [1:0] r1,
  input  logic [1:0] r2,
  output logic       legal
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;

  logic slide_r, slide_l, jump_r, jump_l;

  // With exactly one empty cell, "neighbour is empty" is the same as e == m+-1 / m+-2.
  assign slide_r = (r1 == EMPTY) && (!STRICT || c == RIGHT);
  assign slide_l = (l1 == EMPTY) && (!STRICT || c == LEFT);
  assign jump_r  = (c == RIGHT) && (r1 == LEFT)  && (r2 == EMPTY);
  assign jump_l  = (c == LEFT)  && (l1 == RIGHT) && (l2 == EMPTY);
  assign legal   = (c != EMPTY) && (slide_r || slide_l || jump_r || jump_l);
endmodule

module jam_n #(
  parameter int N      = 3,
  parameter bit STRICT = 1'b0,
  parameter int CW     = 8
) (
  input logic clock,
  input logic reset_n,
  jam_n_if.slave bus
);
  localparam int S  = 2*N + 1;
  localparam int MW = $clog2(S);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;
  localparam logic [1:0] PAD   = 2'd3;

  typedef logic [S-1:0][1:0] board_t;

  function automatic board_t start_board();
    board_t b;
    for (int i = 0; i < S; i++)
      b[i] = (i < N) ? RIGHT : (i == N) ? EMPTY : LEFT;
    return b;
  endfunction

  function automatic board_t goal_board();
    board_t b;
    for (int i = 0; i < S; i++)
      b[i] = (i < N) ? LEFT : (i == N) ? EMPTY : RIGHT;
    return b;
  endfunction

  localparam board_t INIT = start_board();
  localparam board_t GOAL = goal_board();

  board_t        board, board_nxt;
  logic [CW-1:0] cnt;
  logic          accept_q, reject_q;
  logic [S+3:0][1:0] pad;
  logic [S-1:0]  legal_vec;
  logic [MW-1:0] empty_pos;
  logic [MW:0]   n_empty;
  logic [1:0]    cell_m;
  logic          legal_req;
  logic          done, stuck;

  assign pad = {PAD, PAD, board, PAD, PAD};

  for (genvar i = 0; i < S; i++) begin : g_cell
    jam_n_cell #(.STRICT(STRICT)) u_cell (
      .c    (pad[i+2]),
      .l1   (pad[i+1]),
      .l2   (pad[i]),
      .r1   (pad[i+3]),
      .r2   (pad[i+4]),
      .legal(legal_vec[i])
    );
  end

  // Out-of-range requests match no slot, so they stay illegal.
  always_comb begin
    empty_pos = '0;
    n_empty   = '0;
    cell_m    = EMPTY;
    legal_req = 1'b0;
    for (int i = 0; i < S; i++) begin
      if (board[i] == EMPTY) begin
        empty_pos = MW'(i);
        n_empty   = n_empty + (MW+1)'(1);
      end
      if (bus.move == MW'(i)) begin
        cell_m    = board[i];
        legal_req = legal_vec[i];
      end
    end
  end

  always_comb begin
    board_nxt = board;
    for (int i = 0; i < S; i++) begin
      if (empty_pos == MW'(i)) board_nxt[i] = cell_m;
      if (bus.move  == MW'(i)) board_nxt[i] = EMPTY;
    end
  end

  assign done  = (board == GOAL);
  assign stuck = !done && !(|legal_vec);

`ifdef JAM_UNDO_EN
  board_t        hist_board;
  logic [CW-1:0] hist_cnt;
  logic          hist_vld;
`else
  logic unused_undo;
  assign unused_undo = bus.undo;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      board    <= INIT;
      cnt      <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
`ifdef JAM_UNDO_EN
      hist_board <= INIT;
      hist_cnt   <= '0;
      hist_vld   <= 1'b0;
`endif
    end else begin
      accept_q <= 1'b0;
      reject_q <= 1'b0;
`ifdef JAM_UNDO_EN
      // Undo wins; a move requested in the same cycle is silently dropped.
      if (bus.undo) begin
        if (hist_vld) begin
          board    <= hist_board;
          cnt      <= hist_cnt;
          hist_vld <= 1'b0;
          accept_q <= 1'b1;
        end else begin
          reject_q <= 1'b1;
        end
      end else
`endif
      if (bus.move_en) begin
        if (legal_req && !done) begin
          board    <= board_nxt;
          if (cnt != '1) cnt <= cnt + CW'(1);
          accept_q <= 1'b1;
`ifdef JAM_UNDO_EN
          hist_board <= board;
          hist_cnt   <= cnt;
          hist_vld   <= 1'b1;
`endif
        end else begin
          reject_q <= 1'b1;
        end
      end
    end
  end

  a_one_empty: assert property (@(posedge clock) disable iff (!reset_n) n_empty == (MW+1)'(1));

  assign bus.slots     = board;
  assign bus.empty_pos = empty_pos;
  assign bus.accept    = accept_q;
  assign bus.reject    = reject_q;
  assign bus.move_cnt  = cnt;
  assign bus.done      = done;
  assign bus.stuck     = stuck;
endmodule

// File: tb/tb_jam_n.sv
// Bench for jam_n: directed puzzle scenarios plus random requests, on a STRICT=0 and a
// STRICT=1 instance, checked against a slot-array reference model of the puzzle rules.
module tb_jam_n;
  localparam int N  = 3;
  localparam int S  = 2*N + 1;
  localparam int MW = 3;
  localparam int CW = 8;
  localparam int E  = 0;
  localparam int L  = 1;
  localparam int R  = 2;
`ifdef JAM_UNDO_EN
  localparam bit UNDO = 1'b1;
`else
  localparam bit UNDO = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  jam_n_if #(.N(N), .CW(CW)) bus0 ();
  jam_n_if #(.N(N), .CW(CW)) bus1 ();

  jam_n #(.N(N), .STRICT(1'b0), .CW(CW)) dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0.slave));
  jam_n #(.N(N), .STRICT(1'b1), .CW(CW)) dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1.slave));

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  // Reference model: index 0 = free-slide board, index 1 = forward-only board.
  int mb[2][S];
  int hb[2][S];
  int mc[2];
  int hc[2];
  bit hv[2];
  bit macc[2];
  bit mrej[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*S-1:0] bs(input string s);
    logic [2*S-1:0] v;
    v = '0;
    for (int i = 0; i < S; i++)
      case (s[i])
        "R":     v[2*i +: 2] = 2'd2;
        "L":     v[2*i +: 2] = 2'd1;
        default: v[2*i +: 2] = 2'd0;
      endcase
    return v;
  endfunction

  function automatic int m_empty(input int k);
    for (int i = 0; i < S; i++) if (mb[k][i] == E) return i;
    return -1;
  endfunction

  function automatic bit m_legal(input int k, input int m);
    int e, c;
    bit st;
    st = (k == 1);
    if (m < 0 || m > 2*N) return 1'b0;
    c = mb[k][m];
    if (c == E) return 1'b0;
    e = m_empty(k);
    if (e == m+1 && (!st || c == R)) return 1'b1;
    if (e == m-1 && (!st || c == L)) return 1'b1;
    if (c == R && e == m+2 && mb[k][m+1] == L) return 1'b1;
    if (c == L && e == m-2 && mb[k][m-1] == R) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_done(input int k);
    for (int i = 0; i < S; i++)
      if (mb[k][i] != ((i < N) ? L : (i == N) ? E : R)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stuck(input int k);
    if (m_done(k)) return 1'b0;
    for (int i = 0; i < S; i++) if (m_legal(k, i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [2*S-1:0] m_pack(input int k);
    logic [2*S-1:0] v;
    int c;
    for (int i = 0; i < S; i++) begin
      c = mb[k][i];
      v[2*i +: 2] = c[1:0];
    end
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < S; i++) mb[k][i] = (i < N) ? R : (i == N) ? E : L;
      mc[k] = 0; hv[k] = 1'b0; macc[k] = 1'b0; mrej[k] = 1'b0;
    end
  endtask

  task automatic m_edge(input bit en, input int m, input bit u);
    int e;
    for (int k = 0; k < 2; k++) begin
      macc[k] = 1'b0;
      mrej[k] = 1'b0;
      if (UNDO && u) begin
        if (hv[k]) begin
          for (int i = 0; i < S; i++) mb[k][i] = hb[k][i];
          mc[k] = hc[k]; hv[k] = 1'b0; macc[k] = 1'b1;
        end else mrej[k] = 1'b1;
      end else if (en) begin
        if (!m_done(k) && m_legal(k, m)) begin
          for (int i = 0; i < S; i++) hb[k][i] = mb[k][i];
          hc[k] = mc[k]; hv[k] = 1'b1;
          e = m_empty(k);
          mb[k][e] = mb[k][m];
          mb[k][m] = E;
          if (mc[k] < 2**CW - 1) mc[k]++;
          macc[k] = 1'b1;
        end else mrej[k] = 1'b1;
      end
    end
  endtask

  task automatic check_dut(input int k);
    logic [2*S-1:0] sl;
    logic [MW-1:0]  ep;
    logic [CW-1:0]  mcn;
    logic ac, rj, dn, sk;
    if (k == 0) begin
      sl = bus0.slots; ep = bus0.empty_pos; mcn = bus0.move_cnt;
      ac = bus0.accept; rj = bus0.reject; dn = bus0.done; sk = bus0.stuck;
    end else begin
      sl = bus1.slots; ep = bus1.empty_pos; mcn = bus1.move_cnt;
      ac = bus1.accept; rj = bus1.reject; dn = bus1.done; sk = bus1.stuck;
    end
    chk($sformatf("d%0d slots", k),     32'(sl),  32'(m_pack(k)));
    chk($sformatf("d%0d empty_pos", k), 32'(ep),  32'(m_empty(k)));
    chk($sformatf("d%0d move_cnt", k),  32'(mcn), 32'(mc[k]));
    chk($sformatf("d%0d accept", k),    32'(ac),  32'(macc[k]));
    chk($sformatf("d%0d reject", k),    32'(rj),  32'(mrej[k]));
    chk($sformatf("d%0d done", k),      32'(dn),  32'(m_done(k)));
    chk($sformatf("d%0d stuck", k),     32'(sk),  32'(m_stuck(k)));
  endtask

  task automatic drive(input bit en, input int m, input bit u);
    bus0.move_en = en; bus0.move = 3'(m); bus0.undo = u;
    bus1.move_en = en; bus1.move = 3'(m); bus1.undo = u;
  endtask

  task automatic step(input bit en, input int m, input bit u);
    drive(en, m, u);
    @(posedge clock);
    m_edge(en, m, u);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  // Reset is asserted between edges and checked before any edge arrives.
  task automatic do_reset();
    drive(1'b0, 0, 1'b0);
    reset_n = 1'b0;
    #1;
    m_reset();
    chk("rst slots",     32'(bus0.slots),     32'(bs("RRR_LLL")));
    chk("rst empty_pos", 32'(bus0.empty_pos), 32'(N));
    chk("rst move_cnt",  32'(bus0.move_cnt),  32'd0);
    chk("rst accept",    32'(bus0.accept),    32'd0);
    chk("rst reject",    32'(bus0.reject),    32'd0);
    chk("rst done",      32'(bus0.done),      32'd0);
    chk("rst stuck",     32'(bus0.stuck),     32'd0);
    check_dut(1);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sol[15];
    int m;
    bit en, u;
    sol = '{2, 4, 5, 3, 1, 0, 2, 4, 6, 5, 3, 1, 2, 4, 3};
    drive(1'b0, 0, 1'b0);
    #2;
    do_reset();

    // Slide then jump from the start position.
    step(1'b1, 2, 1'b0);
    chk("s1 slots", 32'(bus0.slots),     32'(bs("RR_RLLL")));
    chk("s1 empty", 32'(bus0.empty_pos), 32'd2);
    chk("s1 cnt",   32'(bus0.move_cnt),  32'd1);
    chk("s1 acc",   32'(bus0.accept),    32'd1);
    step(1'b1, 4, 1'b0);
    chk("s2 slots", 32'(bus0.slots),     32'(bs("RRLR_LL")));
    chk("s2 empty", 32'(bus0.empty_pos), 32'd4);
    chk("s2 cnt",   32'(bus0.move_cnt),  32'd2);

    // Illegal and out-of-range requests.
    do_reset();
    step(1'b1, 0, 1'b0);
    chk("s3 rej0",  32'(bus0.reject),   32'd1);
    chk("s3 slots", 32'(bus0.slots),    32'(bs("RRR_LLL")));
    step(1'b1, 7, 1'b0);
    chk("s3 rej7",  32'(bus0.reject),   32'd1);
    chk("s3 cnt",   32'(bus0.move_cnt), 32'd0);
    step(1'b0, 2, 1'b0);
    chk("idle acc", 32'(bus0.accept),   32'd0);

    // Full solution, then the board is frozen.
    do_reset();
    foreach (sol[i]) step(1'b1, sol[i], 1'b0);
    chk("s4 done",  32'(bus0.done),     32'd1);
    chk("s4 cnt",   32'(bus0.move_cnt), 32'd15);
    chk("s4 slots", 32'(bus0.slots),    32'(bs("LLL_RRR")));
    step(1'b1, 2, 1'b0);
    chk("s4 frozen", 32'(bus0.reject),  32'd1);
    chk("s4 cnt2",   32'(bus0.move_cnt), 32'd15);

    // Forward-only instance reaches a dead end.
    do_reset();
    step(1'b1, 4, 1'b0);
    step(1'b1, 5, 1'b0);
    step(1'b1, 6, 1'b0);
    chk("s5 slots", 32'(bus1.slots), 32'(bs("RRRLLL_")));
    chk("s5 stuck", 32'(bus1.stuck), 32'd1);
    chk("s5 done",  32'(bus1.done),  32'd0);
    step(1'b1, 5, 1'b0);
    chk("s5 back rej", 32'(bus1.reject), 32'd1);

    do_reset();
    step(1'b1, 2, 1'b0);
`ifdef JAM_UNDO_EN
    step(1'b0, 0, 1'b1);
    chk("undo slots", 32'(bus0.slots),    32'(bs("RRR_LLL")));
    chk("undo cnt",   32'(bus0.move_cnt), 32'd0);
    chk("undo acc",   32'(bus0.accept),   32'd1);
    step(1'b0, 0, 1'b1);
    chk("undo2 rej",  32'(bus0.reject),   32'd1);
    step(1'b1, 2, 1'b0);
    step(1'b1, 4, 1'b1);
    chk("undo prio slots", 32'(bus0.slots), 32'(bs("RRR_LLL")));
`else
    step(1'b0, 0, 1'b1);
    chk("undo ign acc",   32'(bus0.accept), 32'd0);
    chk("undo ign rej",   32'(bus0.reject), 32'd0);
    chk("undo ign slots", 32'(bus0.slots),  32'(bs("RR_RLLL")));
`endif
    step(1'b1, 4, 1'b0);
    chk("pre-rst acc", 32'(bus0.accept), 32'd1);
    do_reset();

    // Random requests, resetting now and then once a board is finished or stuck.
    for (int n = 0; n < 400; n++) begin
      if ((m_done(0) || m_stuck(0) || m_stuck(1)) && $urandom_range(0, 3) == 0) do_reset();
      m  = $urandom_range(0, 7);
      en = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 9) == 0);
      step(en, m, u);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
